text_overlay: RTL and testbench
===============================

TEXT_OVERLAY -- requirements
Module: text_overlay

Interface
REQ-001 Parameter COLS, default 106: text columns (640 px / 6 px per character cell).
REQ-002 Parameter ROWS, default 60: text rows (480 px / 8 px per character cell).
REQ-003 clk  input  1  sole clock.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 char_x  input  8  character column from the font engine.
REQ-006 char_y  input  8  character row from the font engine.
REQ-007 ascii_char  input  256  per-code pel bits from the font engine, registered, one cycle after char_x/char_y.
REQ-008 blank  input  1  video blanking, aligned with char_x/char_y.
REQ-009 in_valid  input  1  host byte valid.
REQ-010 in_ready  output  1  block accepts a byte.
REQ-011 in_byte  input  8  host character or control byte.
REQ-012 pos_load  input  1  single-cycle strobe that loads the cursor.
REQ-013 pos_x  input  7  cursor column to load.
REQ-014 pos_y  input  6  cursor row to load.
REQ-015 pixel  output  1  overlay pel, 1 = lit.
REQ-016 blank_out  output  1  blank delayed to align with pixel.
REQ-017 cursor_x  output  7  current cursor column.
REQ-018 cursor_y  output  6  current cursor row.

Function
REQ-019 Text store: 8192 x 8 bits, address {row[5:0], col[6:0]}, one write port and one synchronous read port.
REQ-020 Read address is {char_y[5:0], char_x[6:0]}; the code read is available one cycle later, aligned with ascii_char.
REQ-021 Pixel path:
- pixel <= ascii_char[code_q] & ~blank_d1, registered.
- Latency from char_x/char_y to pixel is 2 cycles.
- blank_out = blank delayed by 2 cycles.
REQ-022 Scan positions with char_x >= COLS or char_y >= ROWS produce pixel = 0.
REQ-023 A byte transfers when in_valid & in_ready are both 1 on a rising clk edge.
REQ-024 The FSM has two states, CLEAR and RUN; in_ready = 1 only in RUN.
REQ-025 CLEAR state:
- Writes 0x20 to all 8192 addresses using a 13-bit counter, one address per cycle.
- Moves to RUN the cycle after address 8191 is written.
- Cursor is held at (0,0).
REQ-026 RUN, printable byte 0x20-0x7E:
- Written at the cursor.
- cursor_x increments.
- At cursor_x = COLS-1, cursor_x becomes 0 and cursor_y advances.
REQ-027 RUN, 0x0D (CR): cursor_x becomes 0; no write.
REQ-028 RUN, 0x0A (LF): cursor_y advances; cursor_x is unchanged; no write.
REQ-029 RUN, 0x0C (FF): enter CLEAR; the cursor is homed.
REQ-030 RUN, any other byte: consumed and ignored.
REQ-031 cursor_y advance wraps from ROWS-1 to 0; no scrolling.
REQ-032 pos_load in RUN loads the cursor:
- Columns clamp to COLS-1 and rows clamp to ROWS-1.
- pos_load has priority over a same-cycle byte, which is still consumed, using the loaded position for a printable byte.
REQ-033 pos_load in CLEAR is ignored.
REQ-034 Write and read of the same address in the same cycle returns the old data; the new data is visible from the next frame.

Reset
REQ-035 When reset is asserted:
- FSM is in CLEAR with the clear counter at 0.
- Cursor is (0,0); pixel = 0; blank_out = 1; in_ready = 0.
- Pipeline registers are 0.
REQ-036 Reset asserted mid-CLEAR or mid-RUN restarts a full clear; RAM contents are not reset directly.

Structure
REQ-037 Package text_overlay_pkg holds:
- COLS and ROWS defaults, and ADDR_W = 13.
- Control codes CR, LF, FF and the SPACE fill value.
- The state enum {CLEAR, RUN}.
REQ-038 The sub-module text_ram implements the simple dual-port 8192 x 8 store with registered read and no reset.

Verification
REQ-039 Reset released -> in_ready = 0 for exactly 8192 cycles, then 1; every scan cell then shows ascii_char[0x20], which is all 0.
REQ-040 Send 0x41 at home, drive char_x = 0, char_y = 0 with ascii_char[0x41] = 1 -> pixel = 1 two cycles later; cursor = (1,0).
REQ-041 Send 106 printable bytes -> cursor = (0,1); 107th byte written at {1,0}.
REQ-042 pos_load (5,59), then send 0x0A -> cursor = (5,0); then send 0x0D -> cursor = (0,0).
REQ-043 Send 0x0C with in_valid held -> in_ready low for 8192 cycles; next byte written at (0,0).
REQ-044 Assert reset at clear address 4000 -> after release, in_ready = 0 for a full 8192 cycles.

Source files
------------

// File: rtl/text_overlay_pkg.sv
// Shared constants, types and helpers for the text overlay block.
package text_overlay_pkg;

  localparam int unsigned COLS_DEF = 106;
  localparam int unsigned ROWS_DEF = 60;
  localparam int unsigned ADDR_W   = 13;
  localparam int unsigned COL_W    = 7;
  localparam int unsigned ROW_W    = 6;
  localparam int unsigned DATA_W   = 8;

  localparam logic [DATA_W-1:0] CR    = 8'h0D;
  localparam logic [DATA_W-1:0] LF    = 8'h0A;
  localparam logic [DATA_W-1:0] FF    = 8'h0C;
  localparam logic [DATA_W-1:0] SPACE = 8'h20;

  typedef enum logic {CLEAR, RUN} state_t;

  // Text store write-port payload
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ram_wr_t;

  function automatic logic is_printable(input logic [DATA_W-1:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_ram.sv
// Simple dual-port text store: one write port, registered read, no reset.
module text_ram
  import text_overlay_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Read-before-write: a same-address read returns the old contents
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/text_overlay.sv
// Character-cell text overlay: host byte stream into a text store, scanned
// out against the font engine's per-code pel bits.
module text_overlay
  import text_overlay_pkg::*;
#(
  parameter int unsigned COLS = COLS_DEF,
  parameter int unsigned ROWS = ROWS_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   char_x,
  input  logic [7:0]   char_y,
  input  logic [255:0] ascii_char,
  input  logic         blank,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  input  logic         pos_load,
  input  logic [6:0]   pos_x,
  input  logic [5:0]   pos_y,
  output logic         pixel,
  output logic         blank_out,
  output logic [6:0]   cursor_x,
  output logic [5:0]   cursor_y
);

  localparam logic [COL_W-1:0]  X_MAX    = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  Y_MAX    = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [COL_W-1:0]  cur_x_q, cur_x_d, base_x;
  logic [ROW_W-1:0]  cur_y_q, cur_y_d, base_y;
  logic              ready_q;
  logic              wr_en;
  ram_wr_t           wr;
  logic [7:0]        code_q;
  logic              blank_d1, oob_d1;

  function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] y);
    return (y == Y_MAX) ? '0 : ROW_W'(y + 1'b1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      ready_q   <= (state_d == RUN);
    end
  end

  // Next state, cursor update and text store write
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    wr_en     = 1'b0;
    wr        = '{addr: clr_cnt_q, data: SPACE};
    base_x    = cur_x_q;
    base_y    = cur_y_q;
    unique case (state_q)
      CLEAR: begin
        wr_en     = 1'b1;
        clr_cnt_d = ADDR_W'(clr_cnt_q + 1'b1);
        cur_x_d   = '0;
        cur_y_d   = '0;
        if (clr_cnt_q == CNT_LAST) state_d = RUN;
      end
      RUN: begin
        // A loaded position takes effect before any same-cycle byte
        if (pos_load) begin
          base_x = (pos_x > X_MAX) ? X_MAX : pos_x;
          base_y = (pos_y > Y_MAX) ? Y_MAX : pos_y;
        end
        cur_x_d = base_x;
        cur_y_d = base_y;
        if (in_valid) begin
          if (is_printable(in_byte)) begin
            wr_en = 1'b1;
            wr    = '{addr: {base_y, base_x}, data: in_byte};
            if (base_x == X_MAX) begin
              cur_x_d = '0;
              cur_y_d = next_row(base_y);
            end else begin
              cur_x_d = COL_W'(base_x + 1'b1);
            end
          end else if (in_byte == CR) begin
            cur_x_d = '0;
          end else if (in_byte == LF) begin
            cur_y_d = next_row(base_y);
          end else if (in_byte == FF) begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
            cur_x_d   = '0;
            cur_y_d   = '0;
          end
        end
      end
    endcase
  end

  text_ram u_ram (
    .clk     (clk),
    .we      (wr_en),
    .wr_addr (wr.addr),
    .wr_data (wr.data),
    .rd_addr ({char_y[5:0], char_x[6:0]}),
    .rd_data (code_q)
  );

  // Scan-out: code_q lines up with ascii_char one cycle after the address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blank_d1  <= 1'b0;
      oob_d1    <= 1'b0;
      pixel     <= 1'b0;
      blank_out <= 1'b1;
    end else begin
      blank_d1  <= blank;
      oob_d1    <= (char_x >= 8'(COLS)) || (char_y >= 8'(ROWS));
      pixel     <= ascii_char[code_q] & ~blank_d1 & ~oob_d1;
      blank_out <= blank_d1;
    end
  end

  assign in_ready = ready_q;
  assign cursor_x = cur_x_q;
  assign cursor_y = cur_y_q;

endmodule

// File: tb/tb_text_overlay.sv
// Randomized self-checking bench for text_overlay against a cell/cursor model.
module tb_text_overlay;

  localparam int COLS  = 106;
  localparam int ROWS  = 60;
  localparam int CELLS = 8192;

  logic         clk, reset;
  logic [7:0]   char_x, char_y;
  logic [255:0] ascii_char;
  logic         blank, in_valid, in_ready, pos_load, pixel, blank_out;
  logic [7:0]   in_byte;
  logic [6:0]   pos_x, cursor_x;
  logic [5:0]   pos_y, cursor_y;

  int total = 0;
  int bad   = 0;
  byte unsigned shadow [CELLS];
  int mx, my;
  int written[$];

  text_overlay #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .char_x(char_x), .char_y(char_y),
    .ascii_char(ascii_char), .blank(blank), .in_valid(in_valid),
    .in_ready(in_ready), .in_byte(in_byte), .pos_load(pos_load),
    .pos_x(pos_x), .pos_y(pos_y), .pixel(pixel), .blank_out(blank_out),
    .cursor_x(cursor_x), .cursor_y(cursor_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [255:0] one_hot(input int code);
    logic [255:0] v;
    v = '0;
    v[code] = 1'b1;
    return v;
  endfunction

  function automatic int addr_of(input int x, input int y);
    return (y % 64) * 128 + (x % 128);
  endfunction

  function automatic logic exp_pix(input int x, input int y, input logic [255:0] v);
    if (x >= COLS || y >= ROWS) return 1'b0;
    return v[shadow[addr_of(x, y)]];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < CELLS; i++) shadow[i] = 8'h20;
    mx = 0;
    my = 0;
    written.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      shadow[addr_of(mx, my)] = b;
      written.push_back(addr_of(mx, my));
      mx = mx + 1;
      if (mx == COLS) begin
        mx = 0;
        my = (my + 1) % ROWS;
      end
    end else if (b == 8'h0D) mx = 0;
    else if (b == 8'h0A) my = (my + 1) % ROWS;
    else if (b == 8'h0C) model_clear();
  endtask

  task automatic model_pos(input int x, input int y);
    mx = (x > COLS - 1) ? COLS - 1 : x;
    my = (y > ROWS - 1) ? ROWS - 1 : y;
  endtask

  task automatic scan_cell(input int x, input int y, input logic [255:0] v, output logic pix);
    char_x = 8'(x);
    char_y = 8'(y);
    blank  = 1'b0;
    step();
    ascii_char = v;
    step();
    pix = pixel;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 20000) begin
      n++;
      step();
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_byte  = b;
    wait_ready(n);
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, need 1", in_ready, n);
    end
    step();
    in_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic load_pos(input int x, input int y);
    pos_load = 1'b1;
    pos_x    = 7'(x);
    pos_y    = 6'(y);
    step();
    pos_load = 1'b0;
    model_pos(x, y);
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0;
    repeat (3) step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %0b need 0", in_ready); end
    total++; if (pixel !== 1'b0) begin bad++; $display("FAIL rst_pixel: got %0b need 0", pixel); end
    total++; if (blank_out !== 1'b1) begin bad++; $display("FAIL rst_blank_out: got %0b need 1", blank_out); end
    total++; if (cursor_x !== 7'd0 || cursor_y !== 6'd0) begin
      bad++; $display("FAIL rst_cursor: got (%0d,%0d) need (0,0)", cursor_x, cursor_y);
    end
    reset = 1'b1;
    n = 0;
    while (!in_ready && n < 20000) begin
      pos_load = (n == 100);
      pos_x = 7'd9;
      pos_y = 6'd9;
      n++;
      step();
      if (n == 101) begin
        total++;
        if (cursor_x !== 7'd0 || cursor_y !== 6'd0) begin
          bad++; $display("FAIL clear_pos_ignored: got (%0d,%0d) need (0,0)", cursor_x, cursor_y);
        end
      end
    end
    pos_load = 1'b0;
    model_clear();
    total++; if (n !== 8192) begin bad++; $display("FAIL clear_len: got %0d need 8192", n); end
  endtask

  task automatic test_blank_fill();
    logic pix, want;
    logic [255:0] v;
    int x, y;
    for (int i = 0; i < 10; i++) begin
      x = (i < 2) ? COLS + i * 20 : $urandom_range(COLS - 1);
      y = (i == 2) ? ROWS + 3 : $urandom_range(ROWS - 1);
      v = rand_vec();
      if (i >= 5) v = ~one_hot(8'h20);
      scan_cell(x, y, v, pix);
      want = exp_pix(x, y, v);
      total++;
      if (pix !== want) begin bad++; $display("FAIL fill_cell(%0d,%0d): got %0b need %0b", x, y, pix, want); end
    end
  endtask

  task automatic test_blank();
    ascii_char = '1;
    char_x = 8'd3;
    char_y = 8'd3;
    blank  = 1'b0;
    repeat (3) step();
    blank = 1'b1;
    step();
    total++; if (blank_out !== 1'b0) begin bad++; $display("FAIL blank_lat1: got %0b need 0", blank_out); end
    step();
    total++; if (blank_out !== 1'b1 || pixel !== 1'b0) begin
      bad++; $display("FAIL blank_lat2: got blank_out=%0b pixel=%0b need 1,0", blank_out, pixel);
    end
    blank = 1'b0;
    step();
    total++; if (blank_out !== 1'b1) begin bad++; $display("FAIL unblank_lat1: got %0b need 1", blank_out); end
    step();
    total++; if (blank_out !== 1'b0 || pixel !== 1'b1) begin
      bad++; $display("FAIL unblank_lat2: got blank_out=%0b pixel=%0b need 0,1", blank_out, pixel);
    end
  endtask

  task automatic test_single_char();
    logic pix;
    send_byte(8'h41);
    total++; if (cursor_x !== 7'(mx) || cursor_y !== 6'(my) || mx != 1) begin
      bad++; $display("FAIL char_cursor: got (%0d,%0d) need (1,0)", cursor_x, cursor_y);
    end
    scan_cell(0, 0, one_hot(8'h41), pix);
    total++; if (pix !== 1'b1) begin bad++; $display("FAIL char_pixel_hit: got %0b need 1", pix); end
    scan_cell(0, 0, one_hot(8'h20), pix);
    total++; if (pix !== 1'b0) begin bad++; $display("FAIL char_pixel_miss: got %0b need 0", pix); end
  endtask

  task automatic test_line_wrap();
    logic pix;
    int chk [3];
    load_pos(0, 0);
    for (int i = 0; i < COLS; i++) send_byte(8'($urandom_range(8'h7E, 8'h20)));
    total++; if (cursor_x !== 7'd0 || cursor_y !== 6'd1) begin
      bad++; $display("FAIL wrap_cursor: got (%0d,%0d) need (0,1)", cursor_x, cursor_y);
    end
    send_byte(8'h7E);
    chk = '{addr_of(0, 1), addr_of(COLS - 1, 0), addr_of(0, 0)};
    foreach (chk[i]) begin
      scan_cell(chk[i] % 128, chk[i] / 128, one_hot(shadow[chk[i]]), pix);
      total++; if (pix !== 1'b1) begin bad++; $display("FAIL wrap_cell[%0d]: got %0b need 1", i, pix); end
    end
  endtask

  task automatic test_pos_ctrl();
    logic pix;
    load_pos(5, 59);
    send_byte(8'h0A);
    total++; if (cursor_x !== 7'd5 || cursor_y !== 6'd0) begin
      bad++; $display("FAIL lf_cursor: got (%0d,%0d) need (5,0)", cursor_x, cursor_y);
    end
    send_byte(8'h0D);
    total++; if (cursor_x !== 7'd0 || cursor_y !== 6'd0) begin
      bad++; $display("FAIL cr_cursor: got (%0d,%0d) need (0,0)", cursor_x, cursor_y);
    end
    load_pos(127, 63);
    total++; if (cursor_x !== 7'd105 || cursor_y !== 6'd59) begin
      bad++; $display("FAIL clamp_cursor: got (%0d,%0d) need (105,59)", cursor_x, cursor_y);
    end
    send_byte(8'h5A);
    total++; if (cursor_x !== 7'd0 || cursor_y !== 6'd0) begin
      bad++; $display("FAIL corner_wrap: got (%0d,%0d) need (0,0)", cursor_x, cursor_y);
    end
    send_byte(8'h07);
    send_byte(8'h7F);
    send_byte(8'hC1);
    total++; if (cursor_x !== 7'd0 || cursor_y !== 6'd0) begin
      bad++; $display("FAIL ignore_cursor: got (%0d,%0d) need (0,0)", cursor_x, cursor_y);
    end
    scan_cell(COLS - 1, ROWS - 1, one_hot(8'h5A), pix);
    total++; if (pix !== 1'b1) begin bad++; $display("FAIL corner_cell: got %0b need 1", pix); end
    scan_cell(0, 0, one_hot(shadow[0]), pix);
    total++; if (pix !== 1'b1) begin bad++; $display("FAIL ignore_cell: got %0b need 1", pix); end
  endtask

  task automatic test_pos_and_byte();
    logic pix;
    pos_load = 1'b1; pos_x = 7'd10; pos_y = 6'd3;
    in_valid = 1'b1; in_byte = 8'h5A;
    step();
    pos_load = 1'b0; in_valid = 1'b0;
    model_pos(10, 3);
    model_byte(8'h5A);
    total++; if (cursor_x !== 7'd11 || cursor_y !== 6'd3) begin
      bad++; $display("FAIL posbyte_cursor: got (%0d,%0d) need (11,3)", cursor_x, cursor_y);
    end
    scan_cell(10, 3, one_hot(8'h5A), pix);
    total++; if (pix !== 1'b1) begin bad++; $display("FAIL posbyte_cell: got %0b need 1", pix); end
    pos_load = 1'b1; pos_x = 7'd50; pos_y = 6'd7;
    in_valid = 1'b1; in_byte = 8'h0D;
    step();
    pos_load = 1'b0; in_valid = 1'b0;
    model_pos(50, 7);
    model_byte(8'h0D);
    total++; if (cursor_x !== 7'd0 || cursor_y !== 6'd7) begin
      bad++; $display("FAIL poscr_cursor: got (%0d,%0d) need (0,7)", cursor_x, cursor_y);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom_range(8'h7E, 8'h20));
      in_byte = b;
      step();
      model_byte(b);
    end
    in_valid = 1'b0;
    total++; if (cursor_x !== 7'(mx) || cursor_y !== 6'(my)) begin
      bad++; $display("FAIL b2b_cursor: got (%0d,%0d) need (%0d,%0d)", cursor_x, cursor_y, mx, my);
    end
  endtask

  task automatic test_random();
    int op, idx, x, y;
    logic [7:0] b;
    logic [255:0] v;
    logic pix, want;
    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(9);
      if (op <= 5) send_byte(8'($urandom_range(8'h7E, 8'h20)));
      else if (op == 6) send_byte(8'h0D);
      else if (op == 7) send_byte(8'h0A);
      else if (op == 8) begin
        b = 8'($urandom);
        if (b == 8'h0C) b = 8'h0B;
        send_byte(b);
      end else load_pos($urandom_range(127), $urandom_range(63));
      total++; if (cursor_x !== 7'(mx) || cursor_y !== 6'(my)) begin
        bad++; $display("FAIL rand_cursor[%0d]: got (%0d,%0d) need (%0d,%0d)", i, cursor_x, cursor_y, mx, my);
      end
    end
    for (int i = 0; i < 30; i++) begin
      if (i < 20 && written.size() > 0) begin
        idx = written[$urandom_range(written.size() - 1)];
        x = idx % 128;
        y = idx / 128;
        v = one_hot(shadow[idx]);
      end else begin
        x = $urandom_range(COLS + 4);
        y = $urandom_range(ROWS + 2);
        v = rand_vec();
      end
      scan_cell(x, y, v, pix);
      want = exp_pix(x, y, v);
      total++; if (pix !== want) begin bad++; $display("FAIL rand_cell(%0d,%0d): got %0b need %0b", x, y, pix, want); end
    end
  endtask

  task automatic test_ff();
    int n, old_idx;
    logic pix;
    old_idx = written.size() > 0 ? written[0] : addr_of(0, 0);
    in_valid = 1'b1;
    in_byte  = 8'h0C;
    wait_ready(n);
    step();
    model_byte(8'h0C);
    in_byte = 8'h33;
    wait_ready(n);
    total++; if (n !== 8192) begin bad++; $display("FAIL ff_clear_len: got %0d need 8192", n); end
    total++; if (cursor_x !== 7'd0 || cursor_y !== 6'd0) begin
      bad++; $display("FAIL ff_home: got (%0d,%0d) need (0,0)", cursor_x, cursor_y);
    end
    step();
    in_valid = 1'b0;
    model_byte(8'h33);
    total++; if (cursor_x !== 7'd1 || cursor_y !== 6'd0) begin
      bad++; $display("FAIL ff_next_cursor: got (%0d,%0d) need (1,0)", cursor_x, cursor_y);
    end
    scan_cell(0, 0, one_hot(8'h33), pix);
    total++; if (pix !== 1'b1) begin bad++; $display("FAIL ff_next_cell: got %0b need 1", pix); end
    if (old_idx != addr_of(0, 0)) begin
      scan_cell(old_idx % 128, old_idx / 128, one_hot(8'h20), pix);
      total++; if (pix !== 1'b1) begin bad++; $display("FAIL ff_cleared_cell: got %0b need 1", pix); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic pix;
    load_pos(20, 4);
    send_byte(8'h51);
    reset = 1'b0;
    step();
    reset = 1'b1;
    wait_ready(n);
    model_clear();
    total++; if (n !== 8192) begin bad++; $display("FAIL run_reset_len: got %0d need 8192", n); end
    scan_cell(20, 4, one_hot(8'h20), pix);
    total++; if (pix !== 1'b1) begin bad++; $display("FAIL run_reset_cell: got %0b need 1", pix); end
    send_byte(8'h0C);
    repeat (4000) step();
    reset = 1'b0;
    step();
    total++; if (in_ready !== 1'b0 || cursor_x !== 7'd0 || cursor_y !== 6'd0) begin
      bad++; $display("FAIL midclear_rst: got ready=%0b cursor=(%0d,%0d) need 0,(0,0)", in_ready, cursor_x, cursor_y);
    end
    reset = 1'b1;
    wait_ready(n);
    model_clear();
    total++; if (n !== 8192) begin bad++; $display("FAIL midclear_len: got %0d need 8192", n); end
  endtask

  initial begin
    reset = 1'b0; char_x = '0; char_y = '0; ascii_char = '0; blank = 1'b0;
    in_valid = 1'b0; in_byte = '0; pos_load = 1'b0; pos_x = '0; pos_y = '0;
    model_clear();
    #1;
    test_reset();
    test_blank_fill();
    test_blank();
    test_single_char();
    test_line_wrap();
    test_pos_ctrl();
    test_pos_and_byte();
    test_back_to_back();
    test_random();
    test_ff();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
